// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled SCK/CS_N/MOSI, parallel rx word out,
// single-entry buffered tx word shifted onto MISO, MSB first.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   tx_data/valid/ready  one-entry tx buffer write handshake
//   rx_data, rx_valid    last complete received word, one-clk update pulse
//   busy                 chip select active (synchronised)
//   spi_sck, spi_cs_n    SPI clock and active-low select from the master
//   spi_mosi, spi_miso   serial data in / out
module spi_slave #(
    parameter int DATA_LENGTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_LENGTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [DATA_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    input  logic                   spi_sck,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic                   spi_miso
);

    localparam int CW = (DATA_LENGTH > 2) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_LENGTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr;
    logic                   sck_d, cs_d;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;

    logic                   pending;
    logic [DATA_LENGTH-1:0] tx_buf;
    logic [DATA_LENGTH-1:0] tx_shift;
    logic [DATA_LENGTH-1:0] rx_shift;
    logic [CW-1:0]          bit_cnt;
    logic                   word_done;
    logic                   rx_done;
    logic                   load;
    logic                   wr;
    logic [DATA_LENGTH-1:0] load_word;

    assign sck_s  = sck_sr[SYNC_STAGES-1];
    assign cs_s   = cs_sr[SYNC_STAGES-1];
    assign mosi_s = mosi_sr[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;

    assign tx_ready  = ~pending;
    assign wr        = tx_valid & ~pending;
    // A load always sees the pre-write contents; an empty buffer sends zeros.
    assign load_word = pending ? tx_buf : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sr  <= '0;
            cs_sr   <= '1;
            mosi_sr <= '0;
            sck_d   <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
            sck_d   <= sck_s;
            cs_d    <= cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        spi_miso  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = ACTIVE;
                    load      = 1'b1;
                end
            end
            ACTIVE: begin
                busy     = 1'b1;
                spi_miso = tx_shift[DATA_LENGTH-1];
                // Deselect wins over any simultaneous SCK edge.
                if (cs_rise) begin
                    state_nxt = IDLE;
                end else if (sck_fall && word_done) begin
                    load = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            tx_buf    <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            rx_done   <= 1'b0;
        end else begin
            rx_valid <= rx_done;
            rx_done  <= 1'b0;
            if (rx_done) begin
                rx_data <= rx_shift;
            end

            if (load) begin
                pending <= 1'b0;
            end
            // A write in the load cycle stays pending for the next word.
            if (wr) begin
                tx_buf  <= tx_data;
                pending <= 1'b1;
            end

            if (state == IDLE) begin
                if (cs_fall) begin
                    tx_shift  <= load_word;
                    bit_cnt   <= '0;
                    word_done <= 1'b0;
                end
            end else if (cs_rise) begin
                bit_cnt   <= '0;
                word_done <= 1'b0;
            end else begin
                if (sck_rise) begin
                    rx_shift <= {rx_shift[DATA_LENGTH-2:0], mosi_s};
                    if (bit_cnt == LAST) begin
                        bit_cnt   <= '0;
                        word_done <= 1'b1;
                        rx_done   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                if (sck_fall) begin
                    if (word_done) begin
                        tx_shift  <= load_word;
                        word_done <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[DATA_LENGTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: drives a mode-0 master and a tx writer,
// scores rx words and MISO words against a word-level model.
module tb_spi_slave;

    localparam int DL   = 8;
    localparam int SYNC = 2;
    localparam int HALF = SYNC + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DL-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DL-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          spi_sck;
    logic          spi_cs_n;
    logic          spi_mosi;
    logic          spi_miso;

    int n_cmp = 0;
    int n_bad = 0;

    // Word-level reference state.
    logic          model_pend = 1'b0;
    logic [DL-1:0] model_buf  = '0;
    logic [DL-1:0] last_rx    = '0;
    logic [DL-1:0] exp_rx[$];
    logic [DL-1:0] mosi_q[$];
    logic [DL-1:0] txq[$];
    logic          rdy_prev   = 1'b1;
    logic          rxv_prev   = 1'b0;

    spi_slave #(.DATA_LENGTH(DL), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_load(output logic [DL-1:0] v);
        v          = model_pend ? model_buf : '0;
        model_pend = 1'b0;
    endtask

    // tx writer: offers queued words, records accepted ones in the model.
    initial begin
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge clk);
            if (tx_valid && rdy_prev) begin
                model_buf  = tx_data;
                model_pend = 1'b1;
                tx_valid   = 1'b0;
            end
            if (!tx_valid && txq.size() > 0) begin
                tx_data  = txq.pop_front();
                tx_valid = 1'b1;
            end
            rdy_prev = tx_ready;
        end
    end

    // rx monitor
    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_rx.size() == 0) begin
                check("rx_unexpected", 32'd1, 32'd0);
            end else begin
                last_rx = exp_rx.pop_front();
                check("rx_data", rx_data, last_rx);
            end
            if (rxv_prev) check("rx_pulse_width", 32'd2, 32'd1);
        end
        rxv_prev = rx_valid;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!tx_valid && txq.size() == 0) return;
            @(negedge clk);
        end
        check("tx_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic preload(input logic [DL-1:0] v);
        txq.push_back(v);
        wait_idle();
    endtask

    // One CS frame carrying the words in mosi_q. stop_bits>0 ends the
    // frame after that many SCK rises (by CS or, with use_rst, by reset).
    task automatic xfer(input int stop_bits, input bit use_rst,
                        input int mid_w, input int mid_b,
                        input logic [DL-1:0] mid_val);
        logic [DL-1:0] w, etx, got;
        logic          p;
        int            nw, lat, rises;
        bit            stop;
        nw    = mosi_q.size();
        rises = 0;
        stop  = 0;
        @(negedge clk);
        check("tx_ready_pre", tx_ready, !model_pend);
        spi_cs_n = 1'b0;
        p = model_pend;
        model_load(etx);
        repeat (SYNC) @(negedge clk);
        if (p) check("tx_ready_low", tx_ready, 1'b0);
        @(negedge clk);
        if (p) check("tx_ready_back", tx_ready, 1'b1);
        repeat (HALF - SYNC - 1) @(negedge clk);
        check("busy_active", busy, 1'b1);
        for (int wi = 0; wi < nw && !stop; wi++) begin
            w   = mosi_q.pop_front();
            got = '0;
            for (int b = 0; b < DL; b++) begin
                spi_mosi = w[DL-1-b];
                if (wi == mid_w && b == mid_b) txq.push_back(mid_val);
                repeat (HALF) @(negedge clk);
                got     = {got[DL-2:0], spi_miso};
                spi_sck = 1'b1;
                rises++;
                if (b == DL - 1) exp_rx.push_back(w);
                lat = 0;
                for (int c = 1; c <= HALF; c++) begin
                    @(negedge clk);
                    if (rx_valid && lat == 0) lat = c;
                end
                if (b == DL - 1) check("rx_latency", lat, SYNC + 2);
                if (use_rst && rises == stop_bits) begin
                    spi_sck  = 1'b0;
                    spi_cs_n = 1'b1;
                    rst      = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    model_pend = 1'b0;
                    exp_rx.delete();
                    last_rx = '0;
                    check("rst_tx_ready", tx_ready, 1'b1);
                    check("rst_rx_valid", rx_valid, 1'b0);
                    check("rst_busy", busy, 1'b0);
                    check("rst_miso", spi_miso, 1'b0);
                    check("rst_rx_data", rx_data, '0);
                    repeat (HALF) @(negedge clk);
                    mosi_q.delete();
                    return;
                end
                spi_sck = 1'b0;
                if (b == DL - 1) begin
                    check("miso_word", got, etx);
                    model_load(etx);
                end
                if (rises == stop_bits) begin
                    stop = 1;
                    break;
                end
            end
        end
        mosi_q.delete();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (HALF + SYNC + 2) @(negedge clk);
        check("busy_idle", busy, 1'b0);
        check("rx_outstanding", exp_rx.size(), 0);
        check("rx_hold", rx_data, last_rx);
    endtask

    initial begin
        int nw, sb, mw, mb;
        rst      = 1'b1;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", tx_ready, 1'b1);
        check("reset_rx_data", rx_data, '0);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_miso", spi_miso, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // preloaded tx, single word
        preload(8'h66);
        mosi_q.push_back(8'hAA);
        xfer(-1, 0, -1, 0, '0);

        // nothing buffered: MISO all zero
        mosi_q.push_back(8'h5A);
        xfer(-1, 0, -1, 0, '0);

        // CS aborted after 3 rises, then a clean word
        mosi_q.push_back(8'hFF);
        xfer(3, 0, -1, 0, '0);
        mosi_q.push_back(8'hC3);
        xfer(-1, 0, -1, 0, '0);

        // two words, second tx written during the first
        preload(8'h3C);
        mosi_q.push_back(8'h12);
        mosi_q.push_back(8'h34);
        xfer(-1, 0, 0, 3, 8'h81);

        // reset after 4 bits discards the buffered word
        preload(8'h99);
        mosi_q.push_back(8'h55);
        xfer(4, 1, 0, 1, 8'h77);
        mosi_q.push_back(8'hF0);
        xfer(-1, 0, -1, 0, '0);

        // tx_valid held while the buffer is full
        preload(8'hA5);
        txq.push_back(8'h5C);
        repeat (5) @(negedge clk);
        check("hold_tx_ready", tx_ready, 1'b0);
        mosi_q.push_back(8'h01);
        xfer(-1, 0, -1, 0, '0);
        mosi_q.push_back(8'h02);
        xfer(-1, 0, -1, 0, '0);

        // randomized frames
        for (int t = 0; t < 25; t++) begin
            nw = $urandom_range(1, 3);
            for (int i = 0; i < nw; i++) mosi_q.push_back(DL'($urandom));
            if (!model_pend && txq.size() == 0 && !tx_valid &&
                $urandom_range(0, 1) == 1) preload(DL'($urandom));
            mw = -1;
            mb = 0;
            if ($urandom_range(0, 1) == 1) begin
                mw = $urandom_range(0, nw - 1);
                mb = $urandom_range(2, 5);
            end
            sb = ($urandom_range(0, 4) == 0) ?
                 $urandom_range(1, nw * DL - 1) : -1;
            xfer(sb, 0, mw, mb, DL'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
